pc_fetch_stage: RTL

- IF stage plus IF/ID pipeline register of the 5-stage pipelined MIPS CPU.
- Holds the PC, drives the instruction-ROM address, and selects the next PC from the ID-stage decoder's PCSrc code and the EX-stage branch resolution.
- Latches fetched instructions into IF/ID and applies stall and flush.
- Synchronises the external interrupt request and presents IRQ/PCWatch to the decoder in ID.

---
 rtl/pc_fetch_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_stage.sv
// IF stage + IF/ID register: holds the PC, picks the next PC, latches fetched instructions, syncs IRQ.
// Latency: one cycle from instr_data to ifid_instr; redirect costs 1 bubble from ID, 2 from EX.
// Backpressure: stall holds PC and IF/ID; any redirect overrides stall and inserts a bubble.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] ILLOP_VEC = 32'h8000_0008,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    input  logic [2:0]  id_pcsrc,
    input  logic [31:0] id_jump_target,
    input  logic [31:0] id_jr_target,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    input  logic        stall,
    input  logic        irq_in,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        irq_out,
    output logic        pc_watch
);
    localparam logic [2:0] PCSRC_SEQ = 3'd0;
    localparam logic [2:0] PCSRC_J   = 3'd2;
    localparam logic [2:0] PCSRC_JR  = 3'd3;
    localparam logic [2:0] PCSRC_IRQ = 3'd4;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        irq_s1_q, irq_s2_q, irq_s2_prev_q;
    logic        irq_pend_q, irq_pend_d;

    logic [31:0] pc_plus4;
    logic [2:0]  pcsrc_eff;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        irq_accept;
    logic        irq_rise;

    // Increment only the low 31 bits so the kernel/user mode bit never flips by fall-through.
    assign pc_plus4  = {pc_q[31], pc_q[30:0] + 31'd4};
    // A bubble in ID carries no real decode, so whatever code the decoder emits is ignored.
    assign pcsrc_eff = ifid_valid_q ? id_pcsrc : PCSRC_SEQ;
    assign irq_rise  = irq_s2_q & ~irq_s2_prev_q;

    // Next-PC priority select and IF/ID update: EX branch, then ID redirects, then stall, then sequential.
    always_comb begin
        pc_d            = pc_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_valid_d    = ifid_valid_q;
        redirect        = 1'b1;
        redirect_pc     = ex_branch_target;
        irq_accept      = 1'b0;
        if (!ex_branch_taken) begin
            case (pcsrc_eff)
                PCSRC_IRQ: begin
                    redirect_pc = IRQ_VEC;
                    irq_accept  = 1'b1;
                end
                3'd5, 3'd6, 3'd7: redirect_pc = ILLOP_VEC;
                PCSRC_J:          redirect_pc = id_jump_target;
                PCSRC_JR:         redirect_pc = id_jr_target;
                default:          redirect    = 1'b0;
            endcase
        end
        if (redirect) begin
            pc_d         = redirect_pc;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d            = pc_plus4;
            ifid_pc_d       = pc_q;
            ifid_pc_plus4_d = pc_plus4;
            ifid_instr_d    = instr_data;
            ifid_valid_d    = 1'b1;
        end
    end

    // Pending interrupt: a new rising edge wins over a same-cycle acceptance.
    always_comb begin
        irq_pend_d = irq_pend_q;
        if (irq_rise) begin
            irq_pend_d = 1'b1;
        end else if (irq_accept) begin
            irq_pend_d = 1'b0;
        end
    end

    // PC and IF/ID pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q            <= RESET_PC;
            ifid_pc_q       <= 32'h0;
            ifid_pc_plus4_q <= 32'h0;
            ifid_instr_q    <= NOP_INSTR;
            ifid_valid_q    <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_valid_q    <= ifid_valid_d;
        end
    end

    // Two-flop synchroniser for irq_in, edge-detect history and the pending flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_s1_q      <= 1'b0;
            irq_s2_q      <= 1'b0;
            irq_s2_prev_q <= 1'b0;
            irq_pend_q    <= 1'b0;
        end else begin
            irq_s1_q      <= irq_in;
            irq_s2_q      <= irq_s1_q;
            irq_s2_prev_q <= irq_s2_q;
            irq_pend_q    <= irq_pend_d;
        end
    end

    assign instr_addr    = pc_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus4 = ifid_pc_plus4_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_valid    = ifid_valid_q;
    // Never interrupt a bubble, so the saved return address is always a real instruction PC.
    assign irq_out       = irq_pend_q & ifid_valid_q;
    assign pc_watch      = ifid_pc_q[31];

endmodule
